mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the pipelined LEGv8 datapath; sits directly downstream of execute.
- Holds the EX/MEM register and consumes PCBranch_E, aluResult_E, writeData_E and zero_E plus the M/W control bits.
- Resolves branches, runs loads/stores against a variable-latency data-memory handshake, and drives the MEM/WB register.
- Stalls the upstream pipeline while an access is outstanding.

Parameters:
- N, 64, datapath width.
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY before an access is aborted; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- PCBranch_E  in  N  branch target from execute.
- aluResult_E  in  N  ALU result; used as the memory address.
- writeData_E  in  N  store data.
- zero_E  in  1  ALU zero flag.
- Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E  in  1 each  control bits.
- rd_E  in  5  destination register.
- PCSrc_M  out  1  branch taken (Branch_M & zero_M).
- PCBranch_M  out  N  registered branch target.
- stall_M  out  1  freeze fetch, decode and execute.
- dm_req  out  1  memory request.
- dm_we  out  1  write enable, valid with dm_req.
- dm_addr  out  N  memory address.
- dm_wdata  out  N  store data.
- dm_rdata  in  N  load data, valid with dm_ready.
- dm_ready  in  1  access complete.
- aluResult_W, readData_W  out  N  MEM/WB data.
- RegWrite_W, MemtoReg_W  out  1  MEM/WB control.
- rd_W  out  5  MEM/WB destination register.
- mem_err  out  1  sticky timeout flag.
- align_err  out  1  misaligned-access pulse.

Behaviour:
- Reset: all EX/MEM and MEM/WB fields, the FSM (IDLE), the timeout counter, rdata_q, mem_err and align_err are 0. All outputs read 0 in the cycle after the reset edge.
- EX/MEM register: loads every *_E input on the clock edge when stall_M=0; holds when stall_M=1.
- mem_op = MemRead_M | MemWrite_M. If both are set, the access is a write and readData is 0.
- Branch path: PCSrc_M and PCBranch_M are combinational from the EX/MEM register and do not depend on the FSM. Flushing is external.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - mem_op=0: stall_M=0, remain in IDLE.
  - mem_op=1: stall_M=1, counter cleared, go to BUSY.
- BUSY:
  - dm_req=1; dm_we=MemWrite_M; dm_addr=aluResult_M; dm_wdata=writeData_M; stall_M=1; counter increments.
  - dm_ready=1: rdata_q<=dm_rdata (0 for writes), go to DONE.
  - Otherwise, counter==TIMEOUT_CYCLES-1: mem_err<=1, rdata_q<=0, go to DONE.
  - dm_ready takes priority over timeout in the same cycle.
- DONE: stall_M=0, dm_req=0, go to IDLE.
- dm_req, dm_we, dm_addr, dm_wdata are 0 outside BUSY.
- MEM/WB register:
  - stall_M=0: loads aluResult_M, RegWrite_M, MemtoReg_M, rd_M; readData_W <= rdata_q when in DONE, else 0.
  - stall_M=1: inserts a bubble (RegWrite_W<=0, MemtoReg_W<=0); data fields hold.
- Latency:
  - Non-memory op: 1 cycle EX/MEM to MEM/WB.
  - Memory op: 2 + (cycles until dm_ready) cycles. Minimum 3 (IDLE, BUSY with ready, DONE).
- Reset mid-access: FSM returns to IDLE and dm_req drops after the reset edge. The memory ignores the abandoned request.
- mem_err clears only on reset.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a mem_op with aluResult_M[2:0]!=0 skips BUSY and goes directly to DONE. No dm_req is issued, rdata_q=0, and RegWrite is forced to 0 for that instruction. align_err pulses high for exactly the DONE cycle.
- Undefined: no check is made; align_err is tied to 0; the address passes through unmodified.

Test Plan:
- Reset held 2 cycles, then ALU op (aluResult_E=0x3A, RegWrite_E=1, rd_E=5) -> 2 edges later aluResult_W=0x3A, RegWrite_W=1, rd_W=5; stall_M never asserted.
- Branch_E=1, zero_E=1, PCBranch_E=0x10003 -> after 1 edge PCSrc_M=1, PCBranch_M=0x10003. Repeat with zero_E=0 -> PCSrc_M=0.
- Load at 0x40, dm_ready after 3 BUSY cycles with dm_rdata=0xCAFE -> stall_M high 4 cycles; dm_req high exactly 3 cycles; readData_W=0xCAFE, MemtoReg_W=1, RegWrite_W=0 during stall.
- Store at 0x48, writeData=0xFF, dm_ready same cycle as first BUSY -> dm_we=1, dm_wdata=0xFF for 1 cycle; total stall 2 cycles.
- Load with dm_ready never asserted, TIMEOUT_CYCLES=16 -> dm_req high 16 cycles; mem_err=1 and stays 1; readData_W=0. Reset clears mem_err.
- With MEM_ALIGN_CHECK_EN, load at 0x44 -> no dm_req; align_err high 1 cycle; RegWrite_W=0. Without the macro -> normal access at 0x44.

Source files
------------

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM and MEM/WB registers, branch resolve, and a
// variable-latency data-memory handshake. Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_stage #(
  parameter int N              = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         RegWrite_E,
  input  logic         MemtoReg_E,
  input  logic [4:0]   rd_E,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         stall_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ready,
  output logic [N-1:0] aluResult_W,
  output logic [N-1:0] readData_W,
  output logic         RegWrite_W,
  output logic         MemtoReg_W,
  output logic [4:0]   rd_W,
  output logic         mem_err,
  output logic         align_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} memState_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  memState_t    state, nextState;
  logic [7:0]   timeoutCnt;
  logic [N-1:0] rdata_q;

  logic [N-1:0] aluResult_M, writeData_M;
  logic         zero_M, Branch_M, MemRead_M, MemWrite_M, RegWrite_M, MemtoReg_M;
  logic [4:0]   rd_M;

  logic         memOp;
  logic         misaligned;
  logic         regWriteEff;

  assign memOp   = MemRead_M | MemWrite_M;
  assign PCSrc_M = Branch_M & zero_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned  = memOp & (aluResult_M[2:0] != 3'b000);
  // A rejected access must not write back stale data to the register file.
  assign regWriteEff = RegWrite_M & ~align_err;

  always_ff @(posedge clk) begin
    if (reset) align_err <= 1'b0;
    else       align_err <= (state == IDLE) & misaligned;
  end
`else
  assign misaligned  = 1'b0;
  assign regWriteEff = RegWrite_M;
  assign align_err   = 1'b0;
`endif

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous, so it lives inside the clocked branch and not the sensitivity list.
    if (reset) begin
      PCBranch_M  <= '0;
      aluResult_M <= '0;
      writeData_M <= '0;
      zero_M      <= 1'b0;
      Branch_M    <= 1'b0;
      MemRead_M   <= 1'b0;
      MemWrite_M  <= 1'b0;
      RegWrite_M  <= 1'b0;
      MemtoReg_M  <= 1'b0;
      rd_M        <= '0;
    end else if (!stall_M) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      PCBranch_M  <= PCBranch_E;
      aluResult_M <= aluResult_E;
      writeData_M <= writeData_E;
      zero_M      <= zero_E;
      Branch_M    <= Branch_E;
      MemRead_M   <= MemRead_E;
      MemWrite_M  <= MemWrite_E;
      RegWrite_M  <= RegWrite_E;
      MemtoReg_M  <= MemtoReg_E;
      rd_M        <= rd_E;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    nextState = state;
    stall_M   = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    case (state)
      IDLE: begin
        if (memOp) begin
          stall_M   = 1'b1;
          nextState = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_M  = 1'b1;
        dm_req   = 1'b1;
        dm_we    = MemWrite_M;
        dm_addr  = aluResult_M;
        dm_wdata = writeData_M;
        if (dm_ready || timeoutCnt == TIMEOUT_LAST) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timeoutCnt <= '0;
      rdata_q    <= '0;
      mem_err    <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (memOp) begin
            timeoutCnt <= '0;
            if (misaligned) rdata_q <= '0;
          end
        end
        BUSY: begin
          timeoutCnt <= timeoutCnt + 8'd1;
          // A completing access wins over a timeout landing on the same cycle.
          if (dm_ready) begin
            rdata_q <= MemWrite_M ? '0 : dm_rdata;
          end else if (timeoutCnt == TIMEOUT_LAST) begin
            mem_err <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // MEM/WB pipeline register; a stall injects a bubble but keeps the data fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluResult_W <= '0;
      readData_W  <= '0;
      RegWrite_W  <= 1'b0;
      MemtoReg_W  <= 1'b0;
      rd_W        <= '0;
    end else if (!stall_M) begin
      aluResult_W <= aluResult_M;
      readData_W  <= (state == DONE) ? rdata_q : '0;
      RegWrite_W  <= regWriteEff;
      MemtoReg_W  <= MemtoReg_M;
      rd_W        <= rd_M;
    end else begin
      RegWrite_W  <= 1'b0;
      MemtoReg_W  <= 1'b0;
    end
  end

endmodule
